// File: rtl/conv_kxk_stream_pkg.sv
// Shared helpers for the K x K streaming convolution: width derivation and
// output rescaling (round half toward +inf, then saturate).
package conv_pkg;

    // Wide enough for any practical PW + WW + clog2(K*K).
    localparam int unsigned ACC_MAX = 128;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned pw,
                                              input int unsigned ww,
                                              input int unsigned k);
        return pw + ww + clog2(k * k);
    endfunction

    function automatic logic signed [ACC_MAX-1:0] round_sat(
        input logic signed [ACC_MAX-1:0] acc,
        input int unsigned               shift,
        input int unsigned               pw
    );
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] rnd;
        logic signed [ACC_MAX-1:0] y;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        one = ACC_MAX'(1);
        rnd = '0;
        if (shift > 0) rnd = one <<< (shift - 1);
        y  = (acc + rnd) >>> shift;
        hi = (one <<< (pw - 1)) - one;
        lo = -(one <<< (pw - 1));
        if (y > hi) begin
            y = hi;
        end else if (y < lo) begin
            y = lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/conv_kxk_stream_if.sv
// Pixel, result and weight-load signals of conv_kxk_stream; the block itself
// connects through the slave modport.
interface conv_kxk_stream_if #(
    parameter int PW = 9,
    parameter int WW = 31,
    parameter int AW = 5
);
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic signed [WW-1:0] w_data;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [PW-1:0] in_data;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [PW-1:0] out_data;
    logic                 out_last;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_kxk_stream_line_buffer.sv
// One image row of delay: circular buffer that advances only on enable, so
// dout is the pixel written IMG_W enabled cycles ago.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int PW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] din,
    output logic [PW-1:0] dout
);
    localparam int unsigned PTR_W = clog2(IMG_W);

    logic [PW-1:0]    mem [IMG_W];
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(IMG_W - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    // Read-before-write on the same slot gives exactly one row of delay.
    always_ff @(posedge clk) begin
        if (en) mem[ptr] <= din;
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming K x K signed convolution with loadable weights, valid/ready flow
// control, rounded/saturated rescaling and an end-of-frame marker.
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5,
    parameter int PW        = 9,
    parameter int WW        = 31,
    parameter int OUT_SHIFT = 30
) (
    input  logic              clk,
    input  logic              reset,
    conv_kxk_stream_if.slave  s
);
    localparam int unsigned ACC_W = acc_width(PW, WW, K);
    localparam int unsigned NK    = K * K;
    localparam int unsigned COL_W = clog2(IMG_W);
    localparam int unsigned ROW_W = clog2(IMG_H);

    if (K < 2 || IMG_W < K || IMG_H < K) begin : g_param_check
        $error("conv_kxk_stream: need K >= 2 and image dimensions >= K");
    end

    logic signed [WW-1:0]    weight [NK];
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    accept;
    logic                    complete;
    logic                    frame_end;

    logic [PW-1:0]           lb_in  [K-1];
    logic [PW-1:0]           lb_out [K-1];
    logic signed [PW-1:0]    win    [K][K-1];
    logic signed [PW-1:0]    cur    [K][K];
    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    y;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;
    assign complete   = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
    assign frame_end  = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NK; i++) weight[i] <= '0;
        end else if (s.w_we && (32'(s.w_addr) < NK)) begin
            weight[s.w_addr] <= s.w_data;
        end
    end

    // Line buffer j delays by j+1 rows; the chain is fed by the incoming pixel.
    always_comb begin
        lb_in[0] = s.in_data;
        for (int unsigned j = 1; j < K - 1; j++) lb_in[j] = lb_out[j-1];
    end

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        line_buffer #(
            .IMG_W (IMG_W),
            .PW    (PW)
        ) u_lb (
            .clk   (clk),
            .reset (reset),
            .en    (accept),
            .din   (lb_in[j]),
            .dout  (lb_out[j])
        );
    end

    // win keeps only the K-1 older columns; the newest column is taken live
    // from the incoming pixel and line-buffer outputs so the MAC sees the
    // window including the pixel being accepted this cycle.
    always_comb begin
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) cur[r][c] = win[r][c];
            if (r == K - 1) begin
                cur[r][K-1] = s.in_data;
            end else begin
                cur[r][K-1] = lb_out[K-2-r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) win[r][c] <= cur[r][c+1];
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                acc = acc + ACC_W'(weight[r*K+c]) * ACC_W'(cur[r][c]);
            end
        end
    end

    assign y = PW'(round_sat(ACC_MAX'(acc), OUT_SHIFT, PW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_last  <= 1'b0;
        end else if (complete) begin
            s.out_valid <= 1'b1;
            s.out_data  <= y;
            s.out_last  <= frame_end;
        end else if (s.out_ready) begin
            s.out_valid <= 1'b0;
        end
    end

endmodule
